// File: rtl/muxnvec_pipe_if.sv
// Handshake bundle between NUM_IN vector sources, the registered vector mux and its sink.
// The master side drives sources and sink ready; the slave side is the mux itself.
interface muxnvec_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int NUM_IN = 3,
  parameter int SELW   = $clog2(NUM_IN)
);
  logic [WIDTH-1:0]  d [NUM_IN][DEPTH];
  logic [NUM_IN-1:0] in_valid;
  logic [NUM_IN-1:0] in_ready;
  logic              mode;
  logic [SELW-1:0]   sel;
  logic [DEPTH-1:0]  lane_mask;
  logic [WIDTH-1:0]  y [DEPTH];
  logic [SELW-1:0]   out_src;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output d, in_valid, mode, sel, lane_mask, out_ready,
    input  in_ready, y, out_src, out_valid
  );

  modport slave (
    input  d, in_valid, mode, sel, lane_mask, out_ready,
    output in_ready, y, out_src, out_valid
  );
endinterface

// File: rtl/muxnvec_pipe.sv
// Registered N-way vector mux with fixed-select or round-robin arbitration,
// per-lane merge mask and a one-entry valid/ready output register.
module muxnvec_pipe #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int NUM_IN = 3,
  parameter int SELW   = $clog2(NUM_IN)
) (
  input  logic           clk,
  input  logic           rst_n,
  muxnvec_pipe_if.slave  bus
);

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  rr_grant;
  logic [SELW-1:0]  cand;
  logic             rr_found;
  logic [SELW-1:0]  grant;
  logic             grant_vld;
  logic             granted_valid;
  logic             can_load;
  logic             accept;
  logic [SELW-1:0]  next_ptr;
  logic [WIDTH-1:0] gdata [DEPTH];

  assign can_load = ~bus.out_valid | bus.out_ready;

  // Scan sources starting at rr_ptr, wrapping modulo NUM_IN; first requester wins.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = SELW'((int'(rr_ptr) + k) % NUM_IN);
      if (!rr_found && bus.in_valid[cand]) begin
        rr_found = 1'b1;
        rr_grant = cand;
      end
    end
  end

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    if (bus.mode) begin
      grant     = rr_grant;
      grant_vld = rr_found;
    end else begin
      grant     = bus.sel;
      grant_vld = (int'(bus.sel) < NUM_IN);
    end
  end

  // Loop compare instead of direct indexing keeps an out-of-range sel harmless.
  always_comb begin
    bus.in_ready  = '0;
    granted_valid = 1'b0;
    for (int l = 0; l < DEPTH; l++) gdata[l] = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_vld && grant == SELW'(i)) begin
        bus.in_ready[i] = can_load & rst_n;
        granted_valid   = bus.in_valid[i];
        gdata           = bus.d[i];
      end
    end
  end

  assign accept   = rst_n & grant_vld & can_load & granted_valid;
  assign next_ptr = (grant == SELW'(NUM_IN - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int l = 0; l < DEPTH; l++) bus.y[l] <= '0;
      bus.out_src   <= '0;
      bus.out_valid <= 1'b0;
      rr_ptr        <= '0;
    end else if (accept) begin
      for (int l = 0; l < DEPTH; l++) begin
        if (bus.lane_mask[l]) bus.y[l] <= gdata[l];
      end
      bus.out_src   <= grant;
      bus.out_valid <= 1'b1;
      if (bus.mode) rr_ptr <= next_ptr;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/muxnvec_pipe.md
# muxnvec_pipe

Registered N-way vector multiplexer for the vector datapath: selects one of NUM_IN vector sources (DEPTH lanes of WIDTH bits each) and holds it in a one-entry output register. Each source and the sink use a valid/ready handshake. It supports two modes: fixed select, and round-robin arbitration among requesting sources. A per-lane write mask enables partial (merge) updates of the output vector. It sits between the vector operand/forwarding sources and the vector execute stage, and replaces the combinational three-way vector mux where a pipeline cut and arbitration are needed.

## Interface
- WIDTH, 32, bits per lane
- DEPTH, 4, lanes per vector
- NUM_IN, 3, number of vector sources (≥2)
- SELW, $clog2(NUM_IN), select/grant index width

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous, active-low
- d  in  NUM_IN×DEPTH×WIDTH  unpacked source vectors, d[src][lane]
- in_valid  in  NUM_IN  source src presents valid data
- in_ready  out  NUM_IN  source src transfers this cycle when in_valid[src] & in_ready[src]
- mode  in  1  0 = fixed select by sel, 1 = round-robin
- sel  in  SELW  source index in fixed mode
- lane_mask  in  DEPTH  1 = lane written on accept, 0 = lane keeps its previous y value
- y  out  DEPTH×WIDTH  registered output vector
- out_src  out  SELW  index of the source held in y
- out_valid  out  1  y holds valid data
- out_ready  in  1  sink accepts y this cycle

## Operation
- can_load = ~out_valid | out_ready. The output register is empty or is being drained this cycle.
- Fixed mode (mode=0):
  - grant = sel.
  - in_ready[i] = can_load & (i==sel). All other in_ready bits are 0.
  - If sel ≥ NUM_IN, no grant: all in_ready = 0 and nothing loads.
- Round-robin mode (mode=1):
  - grant = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_IN.
  - in_ready[grant] = can_load. All other in_ready bits are 0.
  - If no in_valid is set, there is no grant.
- Accept = granted source has in_valid & in_ready. On accept:
  - For each lane l: y[l] ← lane_mask[l] ? d[grant][l] : y[l].
  - out_src ← grant; out_valid ← 1.
  - In round-robin mode only: rr_ptr ← (grant+1) mod NUM_IN. Wrap from NUM_IN−1 to 0.
- No accept and out_valid & out_ready: out_valid ← 0. y and out_src keep their values.
- Simultaneous drain and accept in one cycle: the new data loads and out_valid stays 1 (full throughput, one vector per cycle).
- lane_mask = 0 with accept: the transfer still completes (out_valid=1, out_src updated) and y is unchanged.
- rr_ptr is not affected by fixed-mode transfers. mode may change any cycle and takes effect combinationally in that cycle.
- Reset (rst_n=0 at a rising edge), taking priority over everything:
  - y lanes = 0, out_src = 0, out_valid = 0, rr_ptr = 0.
  - in_ready = 0 for all sources while rst_n=0.
  - A transfer in flight when reset asserts is dropped.

## Timing
- Latency: 1 cycle from the accepting edge to y/out_valid.
- in_ready is combinational from out_valid, out_ready, mode, sel, in_valid and rr_ptr. There is no combinational path from d to any output.
- y, out_src and out_valid change only on clk edges.
- Held data: while out_valid=1 and out_ready=0, y and out_src are stable and every in_ready = 0.
- Sources must hold d and in_valid stable until their transfer completes.
- First accept is possible in the first cycle after rst_n returns to 1.

## Test plan
- Fixed select, NUM_IN=3, DEPTH=4:
  - Stimulus: d0[i]=i, d1[i]=i+4, d2[i]=i+8; lane_mask=4'hF; out_ready=1; in_valid=3'b111; sel=0, then 1, then 2.
  - Required: y = {0,1,2,3}, then {4,5,6,7}, then {8,9,10,11}, each one cycle after the select; out_src = 0, 1, 2.
- Invalid sel=3:
  - Required: in_ready=0 and out_valid falls to 0 after the pending output drains.
- Round-robin with all three sources valid:
  - Required: grants 0,1,2,0,1,2; back-to-back, one per cycle.
  - With in_valid=3'b101: grants 0,2,0,2 (source 1 skipped).
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles after a load.
  - Required: y and out_valid held; all in_ready=0; the next source loads in the same cycle out_ready returns to 1; no vector lost or duplicated.
- Lane mask:
  - Stimulus: y={0,1,2,3}, then accept d1 with lane_mask=4'b0101.
  - Required: y={4,1,6,3}.
  - Then lane_mask=0: y unchanged, out_src=1.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 while out_valid=1 and rr_ptr=2.
  - Required, at the next edge: y all 0, out_valid=0, out_src=0.
  - After release, with all sources valid in round-robin mode: first grant is 0.
